// File: rtl/asteroide_pkg.sv
// Shared definitions for the asteroid destroy controller: default sizing,
// coordinate type and the state encodings reported on db_uc_destroi.
package asteroide_pkg;

  localparam int N_ASTEROIDES = 16;
  localparam int ADDR_W       = 4;
  localparam int COORD_W      = 4;

  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [3:0] ST_INICIAL      = 4'h0;
  localparam logic [3:0] ST_ESPERA       = 4'h1;
  localparam logic [3:0] ST_ZERA         = 4'h2;
  localparam logic [3:0] ST_ESPERA_MEM   = 4'h3;
  localparam logic [3:0] ST_COMPARA      = 4'h4;
  localparam logic [3:0] ST_REMOVE       = 4'h5;
  localparam logic [3:0] ST_VERIFICA_RCO = 4'h6;
  localparam logic [3:0] ST_INCREMENTA   = 4'h7;
  localparam logic [3:0] ST_SINALIZA     = 4'h8;
  localparam logic [3:0] ST_ERRO         = 4'hF;

endpackage

// File: rtl/uc_destroi_asteroide_if.sv
// Bus between the game-control side / asteroid memory+flags (master) and
// the destroy controller (slave).
interface uc_destroi_asteroide_if #(
  parameter int ADDR_W  = 4,
  parameter int COORD_W = 4
);
  logic               destroi_asteroide;
  logic [COORD_W-1:0] tiro_x;
  logic [COORD_W-1:0] tiro_y;
  logic               aste_loaded;
  logic [COORD_W-1:0] aste_x;
  logic [COORD_W-1:0] aste_y;
  logic [ADDR_W-1:0]  aste_addr;
  logic               clear_loaded;
  logic               acertou;
  logic [ADDR_W:0]    num_acertos;
  logic               fim_destroi_asteroide;
  logic [3:0]         db_uc_destroi;

  modport master (
    output destroi_asteroide, tiro_x, tiro_y, aste_loaded, aste_x, aste_y,
    input  aste_addr, clear_loaded, acertou, num_acertos,
           fim_destroi_asteroide, db_uc_destroi
  );

  modport slave (
    input  destroi_asteroide, tiro_x, tiro_y, aste_loaded, aste_x, aste_y,
    output aste_addr, clear_loaded, acertou, num_acertos,
           fim_destroi_asteroide, db_uc_destroi
  );
endinterface

// File: rtl/contador_asteroide.sv
// Slot address counter: synchronous clear, count enable, rco flags the last slot.
module contador_asteroide #(
  parameter int N_ASTEROIDES = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_rco
);
  logic [ADDR_W-1:0] r_count;

  // slot index register; clear wins over enable
  always_ff @(posedge clock) begin
    if (reset || i_clr) r_count <= '0;
    else if (i_en)      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_rco   = (r_count == ADDR_W'(N_ASTEROIDES - 1));
endmodule

// File: rtl/uc_destroi_asteroide.sv
// Destroy-asteroid controller: on a shot, scans every slot, compares each
// loaded asteroid with the shot position and clears the hit slot(s).
// Optional feature macro: MULTI_HIT_EN (defined: keep scanning after a hit and
// clear every match; undefined: stop at the first, lowest-index match).
//
// state           | meaning
// INICIAL    (0)  | after reset
// ESPERA     (1)  | idle, waiting for start
// ZERA       (2)  | clear address counter and hit results
// ESPERA_MEM (3)  | wait for memory read data of current slot
// COMPARA    (4)  | compare slot with shot
// REMOVE     (5)  | clear loaded flag, count hit
// VERIFICA_RCO(6) | last slot?
// INCREMENTA (7)  | next slot
// SINALIZA   (8)  | one-cycle done pulse
// ERRO       (F)  | illegal code trap, left only by reset
module uc_destroi_asteroide #(
  parameter int N_ASTEROIDES = asteroide_pkg::N_ASTEROIDES,
  parameter int ADDR_W       = asteroide_pkg::ADDR_W,
  parameter int COORD_W      = asteroide_pkg::COORD_W
) (
  input logic                   clock,
  input logic                   reset,
  uc_destroi_asteroide_if.slave bus
);
  import asteroide_pkg::*;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic              w_hit;
  logic              w_rco;
  logic [ADDR_W-1:0] w_addr;
  logic              r_acertou;
  logic [ADDR_W:0]   r_num;

  // an unloaded slot never counts, even with matching coordinates
  assign w_hit = bus.aste_loaded && (bus.aste_x == bus.tiro_x) && (bus.aste_y == bus.tiro_y);

  contador_asteroide #(
    .N_ASTEROIDES(N_ASTEROIDES),
    .ADDR_W      (ADDR_W)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (r_state == ST_ZERA),
    .i_en   (r_state == ST_INCREMENTA),
    .o_count(w_addr),
    .o_rco  (w_rco)
  );

  // next-state decode; scan ends on the last-slot check, so the counter never wraps
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INICIAL:      w_next = ST_ESPERA;
      ST_ESPERA:       if (bus.destroi_asteroide) w_next = ST_ZERA;
      ST_ZERA:         w_next = ST_ESPERA_MEM;
      ST_ESPERA_MEM:   w_next = ST_COMPARA;
      ST_COMPARA:      w_next = w_hit ? ST_REMOVE : ST_VERIFICA_RCO;
`ifdef MULTI_HIT_EN
      ST_REMOVE:       w_next = ST_VERIFICA_RCO;
`else
      ST_REMOVE:       w_next = ST_SINALIZA;
`endif
      ST_VERIFICA_RCO: w_next = w_rco ? ST_SINALIZA : ST_INCREMENTA;
      ST_INCREMENTA:   w_next = ST_ESPERA_MEM;
      ST_SINALIZA:     w_next = ST_ESPERA;
      default:         w_next = ST_ERRO;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_INICIAL;
    else       r_state <= w_next;
  end

  // hit results: cleared at scan start, held after the scan until the next one
  always_ff @(posedge clock) begin
    if (reset || (r_state == ST_ZERA)) begin
      r_acertou <= 1'b0;
      r_num     <= '0;
    end else if (r_state == ST_REMOVE) begin
      r_acertou <= 1'b1;
      if (r_num != (ADDR_W+1)'(N_ASTEROIDES)) r_num <= r_num + 1'b1;
    end
  end

  assign bus.aste_addr             = w_addr;
  assign bus.clear_loaded          = (r_state == ST_REMOVE);
  assign bus.fim_destroi_asteroide = (r_state == ST_SINALIZA);
  assign bus.acertou               = r_acertou;
  assign bus.num_acertos           = r_num;
  assign bus.db_uc_destroi         = r_state;
endmodule

// File: tb/tb_uc_destroi_asteroide.sv
// Directed bench for uc_destroi_asteroide with N=4 slots. Models the flag
// register (combinational read) and asteroid memory (one-cycle read latency).
module tb_uc_destroi_asteroide;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uc_destroi_asteroide_if #(.ADDR_W(AW), .COORD_W(CW)) ifc();

  uc_destroi_asteroide #(
    .N_ASTEROIDES(N),
    .ADDR_W      (AW),
    .COORD_W     (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.slave)
  );

  logic [CW-1:0] mem_x [N];
  logic [CW-1:0] mem_y [N];
  logic [N-1:0]  cfg_loaded;
  int            clr_hits [N];
  int            clr_snap [N];
  logic [AW-1:0] rd_addr_q;

  assign ifc.aste_loaded = cfg_loaded[ifc.aste_addr] &&
                           (clr_hits[ifc.aste_addr] == clr_snap[ifc.aste_addr]);

  // flag-clear monitor and memory read model (data lags address by one cycle)
  always @(negedge clock) begin
    if (ifc.clear_loaded === 1'b1)
      clr_hits[ifc.aste_addr] <= clr_hits[ifc.aste_addr] + 1;
    ifc.aste_x <= mem_x[rd_addr_q];
    ifc.aste_y <= mem_y[rd_addr_q];
    rd_addr_q  <= ifc.aste_addr;
  end

  int nchk = 0;
  int nerr = 0;
  int fim_at;
  int nfim;
  logic [3:0] dbt [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clr_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (clr_hits[i] != clr_snap[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] clr_count();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += clr_hits[i] - clr_snap[i];
    return 32'(s);
  endfunction

  task automatic setup(input logic [N-1:0] ld, input logic [CW-1:0] tx, input logic [CW-1:0] ty);
    cfg_loaded = ld;
    for (int i = 0; i < N; i++) clr_snap[i] = clr_hits[i];
    ifc.tiro_x = tx;
    ifc.tiro_y = ty;
  endtask

  // k = cycle index after the edge that samples start; start re-driven at p1/p2
  task automatic scan(input int ncyc, input int p1, input int p2);
    @(negedge clock);
    ifc.destroi_asteroide = 1'b1;
    @(negedge clock);
    fim_at = 0;
    nfim   = 0;
    for (int k = 1; k <= ncyc; k++) begin
      ifc.destroi_asteroide = (k == p1) || (k == p2);
      dbt[k] = ifc.db_uc_destroi;
      if (ifc.fim_destroi_asteroide === 1'b1) begin
        nfim++;
        if (fim_at == 0) fim_at = k;
      end
      @(negedge clock);
    end
    ifc.destroi_asteroide = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_db;
    ifc.destroi_asteroide = 1'b0;
    ifc.tiro_x = '0;
    ifc.tiro_y = '0;
    cfg_loaded = '0;
    for (int i = 0; i < N; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_db", ifc.db_uc_destroi, 0);
    chk("rst_addr", ifc.aste_addr, 0);
    chk("rst_clear", ifc.clear_loaded, 0);
    chk("rst_acertou", ifc.acertou, 0);
    chk("rst_num", ifc.num_acertos, 0);
    chk("rst_fim", ifc.fim_destroi_asteroide, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_db", ifc.db_uc_destroi, 1);

    // 1: nothing loaded
    setup(4'b0000, 4'd3, 4'd5);
    scan(22, 0, 0);
    chk("t1_fim_at", fim_at, 17);
    chk("t1_nfim", nfim, 1);
    chk("t1_db_zera", dbt[1], 2);
    chk("t1_db_sinaliza", dbt[17], 8);
    chk("t1_db_espera", dbt[18], 1);
    chk("t1_acertou", ifc.acertou, 0);
    chk("t1_num", ifc.num_acertos, 0);
    chk("t1_clears", clr_count(), 0);

    // 2: slot 2 hit; slot 0 loaded with matching x only
    mem_x[0] = 4'd3; mem_y[0] = 4'd4;
    mem_x[2] = 4'd3; mem_y[2] = 4'd5;
    setup(4'b0101, 4'd3, 4'd5);
    scan(24, 0, 0);
`ifdef MULTI_HIT_EN
    chk("t2_fim_at", fim_at, 18);
`else
    chk("t2_fim_at", fim_at, 13);
`endif
    chk("t2_db_remove", dbt[12], 5);
    chk("t2_mask", clr_mask(), 32'b0100);
    chk("t2_clears", clr_count(), 1);
    chk("t2_acertou", ifc.acertou, 1);
    chk("t2_num", ifc.num_acertos, 1);

    // 3: slot 1 unloaded at shot position, slot 3 loaded there, slot 0 swapped coords
    mem_x[0] = 4'd5; mem_y[0] = 4'd3;
    mem_x[1] = 4'd3; mem_y[1] = 4'd5;
    mem_x[3] = 4'd3; mem_y[3] = 4'd5;
    setup(4'b1001, 4'd3, 4'd5);
    scan(24, 0, 0);
`ifdef MULTI_HIT_EN
    chk("t3_fim_at", fim_at, 18);
`else
    chk("t3_fim_at", fim_at, 17);
`endif
    chk("t3_mask", clr_mask(), 32'b1000);
    chk("t3_clears", clr_count(), 1);
    chk("t3_acertou", ifc.acertou, 1);
    chk("t3_num", ifc.num_acertos, 1);

    // 4: slots 0 and 3 both at (7,7)
    mem_x[0] = 4'd7; mem_y[0] = 4'd7;
    mem_x[3] = 4'd7; mem_y[3] = 4'd7;
    setup(4'b1001, 4'd7, 4'd7);
    scan(24, 0, 0);
    chk("t4_db_remove", dbt[4], 5);
    chk("t4_nfim", nfim, 1);
`ifdef MULTI_HIT_EN
    chk("t4_fim_at", fim_at, 19);
    chk("t4_mask", clr_mask(), 32'b1001);
    chk("t4_num", ifc.num_acertos, 2);
`else
    chk("t4_fim_at", fim_at, 5);
    chk("t4_mask", clr_mask(), 32'b0001);
    chk("t4_num", ifc.num_acertos, 1);
`endif
    chk("t4_acertou", ifc.acertou, 1);

    // 5: reset during COMPARA of a hit slot
    mem_x[0] = 4'd2; mem_y[0] = 4'd2;
    setup(4'b0001, 4'd2, 4'd2);
    @(negedge clock);
    ifc.destroi_asteroide = 1'b1;
    @(negedge clock);
    ifc.destroi_asteroide = 1'b0;
    repeat (2) @(negedge clock);
    chk("t5_db_compara", ifc.db_uc_destroi, 4);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_db", ifc.db_uc_destroi, 0);
    chk("t5_clear", ifc.clear_loaded, 0);
    chk("t5_addr", ifc.aste_addr, 0);
    chk("t5_acertou", ifc.acertou, 0);
    chk("t5_num", ifc.num_acertos, 0);
    chk("t5_fim", ifc.fim_destroi_asteroide, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_db_after", ifc.db_uc_destroi, 1);
    chk("t5_clears", clr_count(), 0);
    chk("t5_still_loaded", ifc.aste_loaded, 1);

    // 6: start re-pulsed mid-scan and during SINALIZA
    setup(4'b0000, 4'd1, 4'd1);
    scan(24, 5, 17);
    chk("t6_nfim", nfim, 1);
    chk("t6_fim_at", fim_at, 17);
    for (int k = 1; k <= 24; k++) begin
      if (k == 1)       exp_db = 4'd2;
      else if (k == 17) exp_db = 4'd8;
      else if (k >= 18) exp_db = 4'd1;
      else begin
        case ((k - 2) % 4)
          0:       exp_db = 4'd3;
          1:       exp_db = 4'd4;
          2:       exp_db = 4'd6;
          default: exp_db = 4'd7;
        endcase
      end
      chk($sformatf("t6_db_k%0d", k), dbt[k], exp_db);
    end
    chk("t6_clears", clr_count(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
